spike_delay_line: RTL

SPIKE_DELAY_LINE -- requirements
Module: spike_delay_line

---
 rtl/spike_delay_line_pkg.sv | 12 +
 rtl/spike_delay_line_if.sv | 31 +++
 rtl/spike_delay_line_channel.sv | 56 +++++
 rtl/spike_delay_line.sv | 84 ++++++++
 4 files changed

// File: rtl/spike_delay_line_pkg.sv
// Shared constants and types for the spike delay line.
// Build option: define SPIKE_DELAY_COUNT_EN to include the output-spike counter.
package snn_delay_pkg;

    localparam int NUM_CH    = 8;
    localparam int DELAY_W   = 3;
    localparam int MAX_DELAY = (1 << DELAY_W) - 1;

    typedef logic [DELAY_W-1:0] delay_t;
    typedef logic [NUM_CH-1:0]  spike_vec_t;

endpackage

// File: rtl/spike_delay_line_if.sv
// Step, configuration and output signals of the spike delay line.
// master drives steps/config; slave is the delay line itself.
interface spike_delay_line_if
    import snn_delay_pkg::*;
#(
    parameter int NUM_CH  = snn_delay_pkg::NUM_CH,
    parameter int DELAY_W = snn_delay_pkg::DELAY_W
);
    localparam int ADDR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               step_en;
    logic [NUM_CH-1:0]  spikes_in;
    logic               cfg_wr;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [DELAY_W-1:0] cfg_delay;
    logic               flush;
    logic [NUM_CH-1:0]  spikes_out;
    logic               out_valid;
    logic [15:0]        spike_count;

    modport master (
        output step_en, spikes_in, cfg_wr, cfg_addr, cfg_delay, flush,
        input  spikes_out, out_valid, spike_count
    );

    modport slave (
        input  step_en, spikes_in, cfg_wr, cfg_addr, cfg_delay, flush,
        output spikes_out, out_valid, spike_count
    );

endinterface

// File: rtl/spike_delay_line_channel.sv
// One delay channel: spike history shift register, delay register and tap mux.
// Build option: SPIKE_DELAY_COUNT_EN exposes the next-output tap for counting.
module spike_delay_channel
    import snn_delay_pkg::*;
#(
    parameter int DELAY_W = snn_delay_pkg::DELAY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_en,
    input  logic               flush,
    input  logic               spike_in,
    input  logic               cfg_we,
    input  logic [DELAY_W-1:0] cfg_delay,
    output logic               spike_out
`ifdef SPIKE_DELAY_COUNT_EN
    ,
    output logic               spike_tap
`endif
);
    localparam int HIST_W = (1 << DELAY_W) - 1;

    logic [HIST_W-1:0]  hist_reg;
    logic [DELAY_W-1:0] delay_reg;
    logic               spike_out_reg;
    // taps[0] is the live input, taps[k] the input k steps ago.
    logic [HIST_W:0]    taps;

    assign taps      = {hist_reg, spike_in};
    assign spike_out = spike_out_reg;
`ifdef SPIKE_DELAY_COUNT_EN
    assign spike_tap = taps[delay_reg];
`endif

    // Delay write, history shift and output load; a step coinciding with a
    // delay write still selects its tap with the old delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_reg      <= '0;
            delay_reg     <= '0;
            spike_out_reg <= 1'b0;
        end else begin
            if (cfg_we) begin
                delay_reg <= cfg_delay;
            end
            if (flush) begin
                hist_reg      <= '0;
                spike_out_reg <= 1'b0;
            end else if (step_en) begin
                hist_reg      <= taps[HIST_W-1:0];
                spike_out_reg <= taps[delay_reg];
            end
        end
    end

endmodule

// File: rtl/spike_delay_line.sv
// Per-channel programmable spike delay line feeding an SNN neuron layer.
// Build option: SPIKE_DELAY_COUNT_EN builds a saturating output-spike counter;
// without it spike_count is tied to zero.
module spike_delay_line
    import snn_delay_pkg::*;
#(
    parameter int NUM_CH  = snn_delay_pkg::NUM_CH,
    parameter int DELAY_W = snn_delay_pkg::DELAY_W
) (
    input  logic              clk,
    input  logic              reset,
    spike_delay_line_if.slave bus
);
    localparam int ADDR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] out_vec;
    logic              out_valid_reg;
    logic              step_fire;

    // A flush swallows a coincident step.
    assign step_fire = bus.step_en & ~bus.flush;

`ifdef SPIKE_DELAY_COUNT_EN
    logic [NUM_CH-1:0] tap_vec;
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        spike_delay_channel #(
            .DELAY_W (DELAY_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .step_en   (bus.step_en),
            .flush     (bus.flush),
            .spike_in  (bus.spikes_in[gi]),
            .cfg_we    (bus.cfg_wr && (bus.cfg_addr == ADDR_W'(gi))),
            .cfg_delay (bus.cfg_delay),
            .spike_out (out_vec[gi])
`ifdef SPIKE_DELAY_COUNT_EN
            ,
            .spike_tap (tap_vec[gi])
`endif
        );
    end

    // out_valid pulses for the cycle after each accepted step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= step_fire;
        end
    end

    assign bus.spikes_out = out_vec;
    assign bus.out_valid  = out_valid_reg;

`ifdef SPIKE_DELAY_COUNT_EN
    logic [15:0] count_reg;
    logic [16:0] count_next;

    // Running total plus the spikes about to be emitted on this step.
    always_comb begin
        count_next = {1'b0, count_reg};
        for (int i = 0; i < NUM_CH; i++) begin
            count_next = count_next + 17'(tap_vec[i]);
        end
    end

    // Saturating counter, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (step_fire) begin
            count_reg <= count_next[16] ? 16'hFFFF : count_next[15:0];
        end
    end

    assign bus.spike_count = count_reg;
`else
    assign bus.spike_count = '0;
`endif

endmodule
